// File: rtl/fft8_controller.sv
// fft8_controller: sequencer for the 8-point radix-2 FFT (bit-reversed load, 3x4 butterflies, unload).
// Define FFT_CTRL_INVERSE_EN to add the inverse input and the tw_conj output for IFFT operation.
module fft8_controller #(
  parameter int BF_LAT = 2,
  parameter int AW     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef FFT_CTRL_INVERSE_EN
  input  logic          inverse,
  output logic          tw_conj,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr,
  output logic          ld_we,
  output logic [AW-1:0] ld_addr,
  output logic          bf_issue,
  output logic [AW-1:0] bf_rd_a,
  output logic [AW-1:0] bf_rd_b,
  output logic [1:0]    tw_idx,
  output logic          bf_we,
  output logic [AW-1:0] bf_wr_a,
  output logic [AW-1:0] bf_wr_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STAGE  = 3'd2,
    S_DRAIN  = 3'd3,
    S_UNLOAD = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // One counter serves LOAD index, butterfly index, drain count and unload index.
  localparam int CW = (BF_LAT > 7) ? $clog2(BF_LAT + 1) : AW;
  localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE_C  = CW'(1'b1);
  localparam logic [CW-1:0] PT_LAST_C  = CW'(3'd7);
  localparam logic [CW-1:0] BF_LAST_C  = CW'(2'd3);
  localparam logic [CW-1:0] DR_LAST_C  = CW'(BF_LAT - 1);
  localparam logic [AW-1:0] ONE_C      = {{(AW-1){1'b0}}, 1'b1};

  function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = {AW{1'b0}};
    for (int k = 0; k < AW; k++) r[k] = v[AW-1-k];
    return r;
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    stage_r, stage_s;

  logic [AW-1:0] bfly_s, half_s, pos_s, rd_a_s;
  logic          busy_s, done_s, ld_we_s, issue_s, valid_s;
  logic [AW-1:0] addr_s, ld_addr_s, bf_rd_a_s, bf_rd_b_s, out_addr_s;
  logic [1:0]    tw_s;

  logic [BF_LAT-1:0] we_sr_r;
  logic [AW-1:0]     wa_sr_r [BF_LAT];
  logic [AW-1:0]     wb_sr_r [BF_LAT];

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    stage_s = stage_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_LOAD;
          cnt_s   = CNT_ZERO_C;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (cnt_r == PT_LAST_C) begin
          state_s = S_STAGE;
          cnt_s   = CNT_ZERO_C;
          stage_s = 2'd0;
        end else begin
          cnt_s = cnt_r + CNT_ONE_C;
        end
      end
      S_STAGE: begin
        if (cnt_r == BF_LAST_C) begin
          state_s = S_DRAIN;
          cnt_s   = CNT_ZERO_C;
        end else begin
          cnt_s = cnt_r + CNT_ONE_C;
        end
      end
      S_DRAIN: begin
        if (cnt_r == DR_LAST_C) begin
          cnt_s = CNT_ZERO_C;
          if (stage_r == 2'd2) begin
            state_s = S_UNLOAD;
            stage_s = 2'd0;
          end else begin
            state_s = S_STAGE;
            stage_s = stage_r + 2'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE_C;
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          if (cnt_r == PT_LAST_C) begin
            state_s = S_DONE;
            cnt_s   = CNT_ZERO_C;
          end else begin
            cnt_s = cnt_r + CNT_ONE_C;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO_C;
        stage_s = 2'd0;
      end
    endcase
  end

  // Output values for the upcoming cycle, decoded from the next state so they can be registered.
  always_comb begin
    half_s     = ONE_C << stage_s;
    bfly_s     = AW'(cnt_s[1:0]);
    pos_s      = bfly_s & (half_s - ONE_C);
    rd_a_s     = ((bfly_s >> stage_s) << (stage_s + 2'd1)) + pos_s;
    busy_s     = (state_s != S_IDLE);
    done_s     = 1'b0;
    addr_s     = {AW{1'b0}};
    ld_we_s    = 1'b0;
    ld_addr_s  = {AW{1'b0}};
    issue_s    = 1'b0;
    bf_rd_a_s  = {AW{1'b0}};
    bf_rd_b_s  = {AW{1'b0}};
    tw_s       = 2'd0;
    valid_s    = 1'b0;
    out_addr_s = {AW{1'b0}};
    case (state_s)
      S_LOAD: begin
        addr_s    = cnt_s[AW-1:0];
        ld_we_s   = 1'b1;
        ld_addr_s = bit_rev(cnt_s[AW-1:0]);
      end
      S_STAGE: begin
        issue_s   = 1'b1;
        bf_rd_a_s = rd_a_s;
        bf_rd_b_s = rd_a_s + half_s;
        tw_s      = 2'(pos_s << (2'd2 - stage_s));
      end
      S_UNLOAD: begin
        valid_s    = 1'b1;
        out_addr_s = cnt_s[AW-1:0];
      end
      S_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO_C;
      stage_r <= 2'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      stage_r <= stage_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      addr      <= {AW{1'b0}};
      ld_we     <= 1'b0;
      ld_addr   <= {AW{1'b0}};
      bf_issue  <= 1'b0;
      bf_rd_a   <= {AW{1'b0}};
      bf_rd_b   <= {AW{1'b0}};
      tw_idx    <= 2'd0;
      out_valid <= 1'b0;
      out_addr  <= {AW{1'b0}};
    end else begin
      busy      <= busy_s;
      done      <= done_s;
      addr      <= addr_s;
      ld_we     <= ld_we_s;
      ld_addr   <= ld_addr_s;
      bf_issue  <= issue_s;
      bf_rd_a   <= bf_rd_a_s;
      bf_rd_b   <= bf_rd_b_s;
      tw_idx    <= tw_s;
      out_valid <= valid_s;
      out_addr  <= out_addr_s;
    end
  end

  // Write-back delay line; only reset clears it, so in-flight write-backs finish across DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_sr_r <= {BF_LAT{1'b0}};
      for (int k = 0; k < BF_LAT; k++) begin
        wa_sr_r[k] <= {AW{1'b0}};
        wb_sr_r[k] <= {AW{1'b0}};
      end
    end else begin
      we_sr_r[0] <= bf_issue;
      wa_sr_r[0] <= bf_rd_a;
      wb_sr_r[0] <= bf_rd_b;
      for (int k = 1; k < BF_LAT; k++) begin
        we_sr_r[k] <= we_sr_r[k-1];
        wa_sr_r[k] <= wa_sr_r[k-1];
        wb_sr_r[k] <= wb_sr_r[k-1];
      end
    end
  end

  assign bf_we   = we_sr_r[BF_LAT-1];
  assign bf_wr_a = wa_sr_r[BF_LAT-1];
  assign bf_wr_b = wb_sr_r[BF_LAT-1];

`ifdef FFT_CTRL_INVERSE_EN
  logic inv_r;

  // Capture the transform direction at start and flag conjugated twiddles on issue cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_r   <= 1'b0;
      tw_conj <= 1'b0;
    end else begin
      if (state_r == S_IDLE && start) begin
        inv_r <= inverse;
      end else begin
        inv_r <= inv_r;
      end
      tw_conj <= (state_s == S_STAGE) && inv_r;
    end
  end
`endif

endmodule

// File: tb/tb_fft8_controller.sv
// Self-checking bench for fft8_controller: per-cycle comparison against a schedule-based reference model.
module tb_fft8_controller;

  localparam int L = 2;
  localparam int P = 3 * (4 + L);

  logic       clk = 1'b0;
  logic       reset, start, out_ready;
  logic       busy, done, ld_we, bf_issue, bf_we, out_valid;
  logic [2:0] addr, ld_addr, bf_rd_a, bf_rd_b, bf_wr_a, bf_wr_b, out_addr;
  logic [1:0] tw_idx;
`ifdef FFT_CTRL_INVERSE_EN
  logic       inverse, tw_conj;
  logic       m_inv;
`endif

  always #5 clk = ~clk;

  fft8_controller #(.BF_LAT(L), .AW(3)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef FFT_CTRL_INVERSE_EN
    .inverse(inverse), .tw_conj(tw_conj),
`endif
    .busy(busy), .done(done), .addr(addr), .ld_we(ld_we), .ld_addr(ld_addr),
    .bf_issue(bf_issue), .bf_rd_a(bf_rd_a), .bf_rd_b(bf_rd_b), .tw_idx(tw_idx),
    .bf_we(bf_we), .bf_wr_a(bf_wr_a), .bf_wr_b(bf_wr_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr)
  );

  typedef struct { int we; int a; int b; } wb_t;

  int  n_checks, n_errs, cyc, acc_cyc;
  int  m_mode, m_k, m_j, m_stalls, stall_seen;
  wb_t hist[$];
  int  e_busy, e_done, e_addr, e_ld_we, e_ld_addr, e_issue, e_rd_a, e_rd_b, e_tw;
  int  e_valid, e_oaddr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_init();
    wb_t z;
    z = '{we: 0, a: 0, b: 0};
    m_mode = 0; m_k = 0; m_j = 0; m_stalls = 0;
    hist.delete();
    for (int i = 0; i < L; i++) hist.push_back(z);
`ifdef FFT_CTRL_INVERSE_EN
    m_inv = 1'b0;
`endif
  endtask

  // Expected outputs from the transform timeline: k counts cycles since start was accepted.
  task automatic compute_expected();
    int r, s, b, half, pos;
    e_busy = (m_mode != 0); e_done = 0; e_addr = 0; e_ld_we = 0; e_ld_addr = 0;
    e_issue = 0; e_rd_a = 0; e_rd_b = 0; e_tw = 0; e_valid = 0; e_oaddr = 0;
    if (m_mode == 1 && m_k <= 8) begin
      e_addr    = m_k - 1;
      e_ld_we   = 1;
      e_ld_addr = ((e_addr & 1) << 2) | (e_addr & 2) | ((e_addr >> 2) & 1);
    end else if (m_mode == 1) begin
      r = m_k - 9;
      s = r / (4 + L);
      b = r % (4 + L);
      if (b < 4) begin
        half    = 1 << s;
        pos     = b % half;
        e_rd_a  = (b / half) * 2 * half + pos;
        e_rd_b  = e_rd_a + half;
        e_tw    = pos * (4 >> s);
        e_issue = 1;
      end
    end else if (m_mode == 2) begin
      e_valid = 1;
      e_oaddr = m_j;
    end else if (m_mode == 3) begin
      e_done = 1;
    end
  endtask

  task automatic compare_outputs();
    compute_expected();
    check_val("busy", busy, e_busy);
    check_val("done", done, e_done);
    check_val("addr", addr, e_addr);
    check_val("ld_we", ld_we, e_ld_we);
    check_val("ld_addr", ld_addr, e_ld_addr);
    check_val("bf_issue", bf_issue, e_issue);
    check_val("bf_rd_a", bf_rd_a, e_rd_a);
    check_val("bf_rd_b", bf_rd_b, e_rd_b);
    check_val("tw_idx", tw_idx, e_tw);
    check_val("bf_we", bf_we, hist[0].we);
    check_val("bf_wr_a", bf_wr_a, hist[0].a);
    check_val("bf_wr_b", bf_wr_b, hist[0].b);
    check_val("out_valid", out_valid, e_valid);
    check_val("out_addr", out_addr, e_oaddr);
`ifdef FFT_CTRL_INVERSE_EN
    check_val("tw_conj", tw_conj, (e_issue != 0 && m_inv) ? 1 : 0);
`endif
    if (done === 1'b1) check_val("done_lat", cyc - acc_cyc, 8 + P + 8 + 1 + m_stalls);
  endtask

  task automatic model_advance(input logic st, input logic rdy);
    wb_t w;
    w = '{we: e_issue, a: e_rd_a, b: e_rd_b};
    hist.push_back(w);
    void'(hist.pop_front());
    case (m_mode)
      0: if (st) begin
        m_mode = 1; m_k = 1; m_stalls = 0; acc_cyc = cyc;
`ifdef FFT_CTRL_INVERSE_EN
        m_inv = inverse;
`endif
      end
      1: if (m_k == 8 + P) begin m_mode = 2; m_j = 0; end else m_k++;
      2: if (rdy) begin
        if (m_j == 7) m_mode = 3; else m_j++;
      end else m_stalls++;
      default: m_mode = 0;
    endcase
  endtask

  task automatic tick(input logic st, input logic rdy);
    start = st; out_ready = rdy;
`ifdef FFT_CTRL_INVERSE_EN
    inverse = 1'($urandom_range(0, 1));
`endif
    @(negedge clk);
    compare_outputs();
    model_advance(st, rdy);
    @(posedge clk); #1;
    cyc++;
  endtask

  // 0: always ready; 1: stall 3 cycles at j=2; 2: random.
  function automatic logic pick_ready(input int mode);
    if (mode == 1) begin
      if (m_mode == 2 && m_j == 2 && stall_seen < 3) begin
        stall_seen++;
        return 1'b0;
      end
      return 1'b1;
    end else if (mode == 2) begin
      return ($urandom_range(0, 3) != 0);
    end
    return 1'b1;
  endfunction

  task automatic run_xfer(input int mode);
    logic st;
    stall_seen = 0;
    tick(1'b1, pick_ready(mode));
    for (int n = 0; n < 400; n++) begin
      if (m_mode == 0) break;
      st = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick(st, pick_ready(mode));
    end
  endtask

  initial begin
    n_checks = 0; n_errs = 0; cyc = 0; acc_cyc = 0; stall_seen = 0;
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
`ifdef FFT_CTRL_INVERSE_EN
    inverse = 1'b0;
`endif
    model_init();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);

    run_xfer(0);
    tick(1'b0, 1'b1);
    run_xfer(1);
    tick(1'b0, 1'b0);

    // start held high: back-to-back transforms, never accepted while busy
    for (int n = 0; n < 80; n++) tick(1'b1, 1'b1);
    for (int n = 0; n < 60 && m_mode != 0; n++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);

    // asynchronous reset in cycle 4 of LOAD
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b1);
    reset = 1'b0;
    model_init();
    #1;
    compare_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    run_xfer(0);

    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'b1);
      run_xfer(2);
    end
    tick(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/fft8_controller.md
# fft8_controller

Sequencer for the 8-point radix-2 hardware FFT. It walks the sample source through addresses 0..7 and loads the working RAM in bit-reversed order. It then issues the 3 stages × 4 butterflies with RAM read/write addresses and twiddle indices, and finally unloads the 8 results over a valid/ready handshake. It holds no sample data itself; it drives address and enable lines for the sample source, working RAM, butterfly unit and output port.

## Interface
- `BF_LAT`, default 2: butterfly pipeline latency in cycles (≥1), issue to write-back.
- `AW`, default 3: address width (log2 of point count); only 3 is supported.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of transform.
- `addr`  out  3  sample-source address during LOAD.
- `ld_we`  out  1  RAM write enable for load.
- `ld_addr`  out  3  RAM load address = bit-reverse of `addr`.
- `bf_issue`  out  1  butterfly operands valid this cycle.
- `bf_rd_a`, `bf_rd_b`  out  3 each  RAM read addresses (upper/lower operand).
- `tw_idx`  out  2  twiddle index W8^k, k = 0..3.
- `bf_we`  out  1  RAM write-back enable (`bf_issue` delayed `BF_LAT`).
- `bf_wr_a`, `bf_wr_b`  out  3 each  write-back addresses (`bf_rd_*` delayed `BF_LAT`).
- `out_valid`  out  1  result available on RAM read port.
- `out_ready`  in  1  consumer accepts result.
- `out_addr`  out  3  RAM read address for unload (combinational-read RAM).

## Operation
- States: IDLE → LOAD → STAGE → DRAIN → (STAGE | UNLOAD) → DONE → IDLE.
- IDLE: `start`=1 → LOAD next cycle. All outputs 0.
- LOAD: 8 cycles, counter i = 0..7; `addr`=i, `ld_we`=1, `ld_addr`={i[0],i[1],i[2]}.
- STAGE s (0..2), butterfly b (0..3), one per cycle:
  - half = 1<<s; pos = b & (half−1); `bf_rd_a` = (b>>s)·2·half + pos; `bf_rd_b` = `bf_rd_a` + half.
  - `tw_idx` = pos << (2−s); `bf_issue`=1.
- DRAIN: `BF_LAT` cycles with `bf_issue`=0, so stage s write-backs land before stage s+1 reads. After s=2 → UNLOAD, otherwise s+1 → STAGE.
- Write-back shift register: `bf_we`/`bf_wr_a`/`bf_wr_b` are exact `BF_LAT`-cycle delays of issue signals. The shift register is cleared only by reset.
- UNLOAD: `out_valid`=1, `out_addr`=j starting at 0; j advances on `out_valid && out_ready`. After the handshake at j=7 → DONE.
- DONE: one cycle, `done`=1, `busy`=1; → IDLE.
- `start` outside IDLE is ignored (not queued).
- Reset low at any time: state IDLE, all counters, shift-register stages and outputs 0 immediately. No partial write-back survives.

## Timing
- `start` sampled high in cycle 0: LOAD occupies cycles 1–8 and STAGE/DRAIN cycles 9–26 (3×(4+`BF_LAT`) = 18 at default). With `out_ready` held high, UNLOAD occupies cycles 27–34, `done` fires in cycle 35, and IDLE resumes in cycle 36.
- Minimum transform: 8 + 3·(4+`BF_LAT`) + 8 + 1 cycles after start.
- `out_addr` and `out_valid` stay stable while `out_valid && !out_ready`.
- All outputs are registered; none depends combinationally on `start` or `out_ready`.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.

## Configuration
- `FFT_CTRL_INVERSE_EN` defined:
  - Adds input `inverse` (1 bit), captured when `start` is accepted.
  - Adds output `tw_conj` (1 bit), equal to the captured value whenever `bf_issue`=1, else 0. The datapath conjugates the twiddle for IFFT.
  - Reset clears the captured value.
- Not defined: neither port exists; forward transform only.

## Test plan
- Reset low mid-LOAD (cycle 4) → all outputs 0 the same cycle. After release, `start` runs a clean full transform from `addr`=0.
- `start` pulse, `out_ready`=1 → `addr` 0..7 in cycles 1–8 with `ld_addr` = 0,4,2,6,1,5,3,7; `done` in cycle 35 exactly.
- Stage issue checks (default `BF_LAT`):
  - Stage 0 (rd_a, rd_b, tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0).
  - Stage 1 = (0,2,0),(1,3,2),(4,6,0),(5,7,2).
  - Stage 2 = (0,4,0),(1,5,1),(2,6,2),(3,7,3).
  - `bf_we` and write addresses match the issue signals exactly 2 cycles later.
- UNLOAD backpressure: `out_ready` low for 3 cycles at j=2 → `out_addr` holds 2, `out_valid` stays 1. `done` is delayed by exactly 3 cycles.
- `start` held high throughout → a second transform begins in cycle 37 (the cycle after IDLE is re-entered in cycle 36). No `start` is accepted while `busy`.
- With `FFT_CTRL_INVERSE_EN`: `inverse`=1 at start → `tw_conj`=1 on all 12 issue cycles, 0 elsewhere. `inverse` toggled mid-run has no effect.
